// File: rtl/csr_trap_unit_if.sv
// Commit-stage <-> CSR/trap unit bus: instruction fields and interrupt levels in, read data and redirect out.
// Purely combinational bundle; no handshake, the committing instruction is never stalled.
interface csr_trap_unit_if #(
    parameter int XLEN = 64
);
    logic            inst_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_index;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] inst_addr;
    logic            inst_ecall;
    logic            inst_ebreak;
    logic            inst_mret;
    logic            irq_msip;
    logic            irq_mtip;
    logic            irq_meip;
    logic [XLEN-1:0] csr_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_taken;

    modport master (
        output inst_valid, csr_op, csr_index, csr_wdata, inst_addr,
               inst_ecall, inst_ebreak, inst_mret, irq_msip, irq_mtip, irq_meip,
        input  csr_rdata, redirect, redirect_pc, trap_taken
    );

    modport slave (
        input  inst_valid, csr_op, csr_index, csr_wdata, inst_addr,
               inst_ecall, inst_ebreak, inst_mret, irq_msip, irq_mtip, irq_meip,
        output csr_rdata, redirect, redirect_pc, trap_taken
    );
endinterface

// File: rtl/csr_trap_unit.sv
// M-mode CSR file and trap controller; read data and redirect are combinational, state updates next edge.
// No backpressure: every committing instruction is resolved in its own cycle.
module csr_trap_unit #(
    parameter int XLEN        = 64,
    parameter int CNT_W       = 64,
    parameter int HART_ID     = 0,
    parameter int VECTORED_EN = 1
) (
    input logic            clk,
    input logic            rst,
    csr_trap_unit_if.slave bus
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MISA_VAL  = {((XLEN == 64) ? 2'b10 : 2'b01), {(XLEN-11){1'b0}}, 9'h100};
    localparam logic [XLEN-1:0] EPC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] TVEC_MASK = {{(XLEN-2){1'b1}}, 1'b0, (VECTORED_EN != 0)};

    logic             mst_mie, mst_mpie;
    logic             mie_msi, mie_mti, mie_mei;
    logic             msip_q, mtip_q, meip_s1, meip_s2;
    logic [XLEN-1:0]  mtvec_q, mepc_q, mcause_q, mscratch_q;
    logic [CNT_W-1:0] mcycle_q, minstret_q;

    // MEIP comes from another clock domain, hence the extra flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip_q  <= 1'b0;
            mtip_q  <= 1'b0;
            meip_s1 <= 1'b0;
            meip_s2 <= 1'b0;
        end else begin
            msip_q  <= bus.irq_msip;
            mtip_q  <= bus.irq_mtip;
            meip_s1 <= bus.irq_meip;
            meip_s2 <= meip_s1;
        end
    end

    logic [XLEN-1:0] old_val, wval, tvec_base, trap_pc;
    logic            impl, ro_const;

    always_comb begin
        old_val  = '0;
        impl     = 1'b1;
        ro_const = 1'b0;
        case (bus.csr_index)
            A_MSTATUS: begin
                old_val[3]     = mst_mie;
                old_val[7]     = mst_mpie;
                old_val[12:11] = 2'b11;
            end
            A_MISA: begin
                old_val  = MISA_VAL;
                ro_const = 1'b1;
            end
            A_MIE: begin
                old_val[3]  = mie_msi;
                old_val[7]  = mie_mti;
                old_val[11] = mie_mei;
            end
            A_MIP: begin
                old_val[3]  = msip_q;
                old_val[7]  = mtip_q;
                old_val[11] = meip_s2;
            end
            A_MTVEC:    old_val = mtvec_q;
            A_MSCRATCH: old_val = mscratch_q;
            A_MEPC:     old_val = mepc_q;
            A_MCAUSE:   old_val = mcause_q;
            A_MCYCLE:   old_val = XLEN'(mcycle_q);
            A_MINSTRET: old_val = XLEN'(minstret_q);
            A_MVENDORID, A_MARCHID, A_MIMPID: ro_const = 1'b1;
            A_MHARTID: begin
                old_val  = XLEN'(HART_ID);
                ro_const = 1'b1;
            end
            default: impl = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.csr_op)
            2'b10:   wval = old_val | bus.csr_wdata;
            2'b11:   wval = old_val & ~bus.csr_wdata;
            default: wval = bus.csr_wdata;
        endcase
    end

    logic csr_act, does_write, illegal, pend_msi, pend_mti, pend_mei;
    logic irq_take, trap, mret_take, csr_we;
    logic [3:0] code;

    // RS/RC with a zero mask is a pure read, so it may target read-only CSRs.
    assign csr_act    = bus.inst_valid && (bus.csr_op != 2'b00);
    assign does_write = (bus.csr_op == 2'b01) || (bus.csr_op[1] && (bus.csr_wdata != '0));
    assign illegal    = csr_act && (!impl || (ro_const && does_write));
    assign pend_msi   = mie_msi & msip_q;
    assign pend_mti   = mie_mti & mtip_q;
    assign pend_mei   = mie_mei & meip_s2;
    assign irq_take   = bus.inst_valid && mst_mie && (pend_mei || pend_msi || pend_mti);
    assign trap       = irq_take || (bus.inst_valid && (illegal || bus.inst_ecall || bus.inst_ebreak));
    assign mret_take  = bus.inst_valid && bus.inst_mret && !trap;
    assign csr_we     = csr_act && does_write && !trap && !mret_take;

    always_comb begin
        code = 4'd0;
        if (irq_take)             code = pend_mei ? 4'd11 : (pend_msi ? 4'd3 : 4'd7);
        else if (illegal)         code = 4'd2;
        else if (bus.inst_ecall)  code = 4'd11;
        else if (bus.inst_ebreak) code = 4'd3;
    end

    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_pc   = (mtvec_q[0] && irq_take) ? tvec_base + XLEN'({code, 2'b00}) : tvec_base;

    assign bus.csr_rdata   = bus.inst_valid ? old_val : '0;
    assign bus.redirect    = trap || mret_take;
    assign bus.redirect_pc = trap ? trap_pc : (mret_take ? mepc_q : '0);
    assign bus.trap_taken  = trap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_msi    <= 1'b0;
            mie_mti    <= 1'b0;
            mie_mei    <= 1'b0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
        end else if (trap) begin
            mepc_q   <= bus.inst_addr & EPC_MASK;
            mcause_q <= {irq_take, (XLEN-1)'(code)};
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
        end else if (mret_take) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
        end else if (csr_we) begin
            case (bus.csr_index)
                A_MSTATUS: begin
                    mst_mie  <= wval[3];
                    mst_mpie <= wval[7];
                end
                A_MIE: begin
                    mie_msi <= wval[3];
                    mie_mti <= wval[7];
                    mie_mei <= wval[11];
                end
                A_MTVEC:    mtvec_q    <= wval & TVEC_MASK;
                A_MEPC:     mepc_q     <= wval & EPC_MASK;
                A_MCAUSE:   mcause_q   <= wval;
                A_MSCRATCH: mscratch_q <= wval;
                default: ;
            endcase
        end
    end

    // A software write to a counter replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_we && (bus.csr_index == A_MCYCLE)) mcycle_q <= wval[CNT_W-1:0];
            else                                       mcycle_q <= mcycle_q + CNT_W'(1);
            if (csr_we && (bus.csr_index == A_MINSTRET)) minstret_q <= wval[CNT_W-1:0];
            else if (bus.inst_valid && !trap)            minstret_q <= minstret_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: a 64-bit-counter instance plus an 8-bit-counter instance.
module tb_csr_trap_unit;
    logic clk, rst;
    logic [63:0] mdl_cyc;

    csr_trap_unit_if #(.XLEN(64)) bus ();
    csr_trap_unit_if #(.XLEN(64)) b8 ();

    csr_trap_unit #(.XLEN(64), .CNT_W(64), .HART_ID(5), .VECTORED_EN(1)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    csr_trap_unit #(.XLEN(64), .CNT_W(8), .HART_ID(0), .VECTORED_EN(1)) dut8 (
        .clk(clk), .rst(rst), .bus(b8));

    typedef struct packed {
        logic [63:0] rd;
        logic        redir;
        logic [63:0] pc;
        logic        trap;
    } exp_t;

    localparam logic [63:0] PC0 = 64'h8000_0200;

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  exp8_q[$];
    string tag8_q[$];
    int    total = 0;
    int    bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) mdl_cyc <= 64'd0;
        else      mdl_cyc <= mdl_cyc + 64'd1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [11:0] idx, input logic [63:0] wd,
                         input logic [63:0] pc, input logic [2:0] flg, input string tag,
                         input logic [63:0] e_rd, input logic e_redir, input logic [63:0] e_pc,
                         input logic e_trap);
        exp_t e;
        bus.inst_valid  = 1'b1;
        bus.csr_op      = op;
        bus.csr_index   = idx;
        bus.csr_wdata   = wd;
        bus.inst_addr   = pc;
        bus.inst_ecall  = flg[2];
        bus.inst_ebreak = flg[1];
        bus.inst_mret   = flg[0];
        e.rd = e_rd; e.redir = e_redir; e.pc = e_pc; e.trap = e_trap;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [11:0] idx, input string tag, input logic [63:0] e_rd);
        issue(2'b10, idx, 64'd0, PC0, 3'b000, tag, e_rd, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic issue8(input logic [1:0] op, input logic [11:0] idx, input logic [63:0] wd,
                          input string tag, input logic [63:0] e_rd);
        exp_t e;
        b8.inst_valid = 1'b1;
        b8.csr_op     = op;
        b8.csr_index  = idx;
        b8.csr_wdata  = wd;
        b8.inst_addr  = PC0;
        e.rd = e_rd; e.redir = 1'b0; e.pc = 64'd0; e.trap = 1'b0;
        exp8_q.push_back(e);
        tag8_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    task automatic quiet();
        bus.inst_valid  = 1'b0;
        bus.inst_ecall  = 1'b0;
        bus.inst_ebreak = 1'b0;
        bus.inst_mret   = 1'b0;
        b8.inst_valid   = 1'b0;
        @(posedge clk); #1;
    endtask

    exp_t  m_e, m8_e;
    string m_t, m8_t;

    always @(negedge clk) begin
        if (rst && bus.inst_valid) begin
            if (exp_q.size() == 0) begin
                check_val("sb_empty", 64'(exp_q.size()), 64'd1);
            end else begin
                m_e = exp_q.pop_front();
                m_t = tag_q.pop_front();
                check_val({m_t, "/rdata"}, bus.csr_rdata, m_e.rd);
                check_val({m_t, "/redirect"}, 64'(bus.redirect), 64'(m_e.redir));
                check_val({m_t, "/trap"}, 64'(bus.trap_taken), 64'(m_e.trap));
                if (m_e.redir) check_val({m_t, "/pc"}, bus.redirect_pc, m_e.pc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && b8.inst_valid) begin
            if (exp8_q.size() == 0) begin
                check_val("sb8_empty", 64'(exp8_q.size()), 64'd1);
            end else begin
                m8_e = exp8_q.pop_front();
                m8_t = tag8_q.pop_front();
                check_val({m8_t, "/rdata"}, b8.csr_rdata, m8_e.rd);
                check_val({m8_t, "/redirect"}, 64'(b8.redirect), 64'(m8_e.redir));
                check_val({m8_t, "/trap"}, 64'(b8.trap_taken), 64'(m8_e.trap));
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.inst_valid = 1'b0; bus.csr_op = 2'b00; bus.csr_index = 12'h000; bus.csr_wdata = 64'd0;
        bus.inst_addr = 64'd0; bus.inst_ecall = 1'b0; bus.inst_ebreak = 1'b0; bus.inst_mret = 1'b0;
        bus.irq_msip = 1'b0; bus.irq_mtip = 1'b0; bus.irq_meip = 1'b0;
        b8.inst_valid = 1'b0; b8.csr_op = 2'b00; b8.csr_index = 12'h000; b8.csr_wdata = 64'd0;
        b8.inst_addr = 64'd0; b8.inst_ecall = 1'b0; b8.inst_ebreak = 1'b0; b8.inst_mret = 1'b0;
        b8.irq_msip = 1'b0; b8.irq_mtip = 1'b0; b8.irq_meip = 1'b0;

        #2;
        check_val("rst_idle_rdata", bus.csr_rdata, 64'd0);
        check_val("rst_idle_redirect", 64'(bus.redirect), 64'd0);
        check_val("rst_idle_trap", 64'(bus.trap_taken), 64'd0);
        bus.inst_valid = 1'b1; bus.csr_op = 2'b10; bus.csr_index = 12'h300;
        #1;
        check_val("rst_mstatus", bus.csr_rdata, 64'h1800);
        bus.inst_valid = 1'b0;
        #20 rst = 1'b1;
        @(posedge clk); #1;

        rd(12'h300, "mstatus0", 64'h1800);
        rd(12'h301, "misa", 64'h8000_0000_0000_0100);
        rd(12'hB00, "mcycle_a", mdl_cyc);
        rd(12'hB00, "mcycle_b", mdl_cyc);
        issue(2'b01, 12'h305, 64'h8000_0101, PC0, 3'b000, "mtvec_wr", 64'd0, 1'b0, 64'd0, 1'b0);
        rd(12'h305, "mtvec_rd", 64'h8000_0101);
        issue(2'b01, 12'h304, 64'h800, PC0, 3'b000, "mie_wr", 64'd0, 1'b0, 64'd0, 1'b0);
        issue(2'b01, 12'h300, 64'h8, PC0, 3'b000, "mie_on", 64'h1800, 1'b0, 64'd0, 1'b0);
        bus.irq_meip = 1'b1;
        rd(12'h344, "meip_lat0", 64'd0);
        rd(12'h344, "meip_lat1", 64'd0);
        issue(2'b00, 12'h344, 64'd0, PC0, 3'b000, "meip_trap", 64'h800, 1'b1, 64'h8000_012C, 1'b1);
        bus.irq_meip = 1'b0;
        rd(12'h342, "meip_cause", 64'h8000_0000_0000_000B);
        rd(12'h341, "meip_epc", PC0);
        rd(12'h300, "meip_mstatus", 64'h1880);

        issue(2'b01, 12'h300, 64'h8, PC0, 3'b000, "mie_on2", 64'h1880, 1'b0, 64'd0, 1'b0);
        issue(2'b01, 12'h305, 64'h8000_0100, PC0, 3'b000, "mtvec_direct", 64'h8000_0101, 1'b0, 64'd0, 1'b0);
        issue(2'b00, 12'h000, 64'd0, 64'h8000_0040, 3'b100, "ecall", 64'd0, 1'b1, 64'h8000_0100, 1'b1);
        rd(12'h341, "ecall_epc", 64'h8000_0040);
        rd(12'h342, "ecall_cause", 64'd11);
        rd(12'h300, "ecall_mstatus", 64'h1880);
        issue(2'b00, 12'h000, 64'd0, PC0, 3'b001, "mret", 64'd0, 1'b1, 64'h8000_0040, 1'b0);
        rd(12'h300, "mret_mstatus", 64'h1888);

        issue(2'b01, 12'h304, 64'h88, PC0, 3'b000, "mie_sw_tm", 64'h800, 1'b0, 64'd0, 1'b0);
        bus.irq_msip = 1'b1;
        bus.irq_mtip = 1'b1;
        rd(12'h344, "msip_lat", 64'd0);
        issue(2'b00, 12'h344, 64'd0, PC0, 3'b000, "msi_trap", 64'h88, 1'b1, 64'h8000_0100, 1'b1);
        bus.irq_msip = 1'b0;
        rd(12'h342, "msi_cause", 64'h8000_0000_0000_0003);
        issue(2'b01, 12'h300, 64'h8, PC0, 3'b000, "mie_on_pend", 64'h1880, 1'b0, 64'd0, 1'b0);
        issue(2'b00, 12'h000, 64'd0, PC0, 3'b000, "mti_trap", 64'd0, 1'b1, 64'h8000_0100, 1'b1);
        bus.irq_mtip = 1'b0;
        rd(12'h342, "mti_cause", 64'h8000_0000_0000_0007);

        issue(2'b01, 12'hF14, 64'h1234, PC0, 3'b000, "hartid_wr", 64'd5, 1'b1, 64'h8000_0100, 1'b1);
        rd(12'h342, "ill_cause", 64'd2);
        issue(2'b01, 12'h7C0, 64'h1, PC0, 3'b000, "unimpl_wr", 64'd0, 1'b1, 64'h8000_0100, 1'b1);
        rd(12'hF14, "hartid_rd", 64'd5);
        issue(2'b01, 12'h344, 64'hFFF, PC0, 3'b000, "mip_wr", 64'd0, 1'b0, 64'd0, 1'b0);
        rd(12'h344, "mip_rd", 64'd0);
        issue(2'b01, 12'h340, 64'hF0F0, PC0, 3'b000, "scr_rw", 64'd0, 1'b0, 64'd0, 1'b0);
        issue(2'b11, 12'h340, 64'h00F0, PC0, 3'b000, "scr_rc", 64'hF0F0, 1'b0, 64'd0, 1'b0);
        issue(2'b10, 12'h340, 64'h000F, PC0, 3'b000, "scr_rs", 64'hF000, 1'b0, 64'd0, 1'b0);
        rd(12'h340, "scr_rd", 64'hF00F);
        issue(2'b01, 12'h340, 64'h1, 64'h8000_0300, 3'b100, "ecall_wr", 64'hF00F, 1'b1, 64'h8000_0100, 1'b1);
        rd(12'h340, "scr_kept", 64'hF00F);
        rd(12'h341, "ecall_wr_epc", 64'h8000_0300);
        issue(2'b01, 12'h341, 64'h8000_0043, PC0, 3'b000, "mepc_wr", 64'h8000_0300, 1'b0, 64'd0, 1'b0);
        rd(12'h341, "mepc_align", 64'h8000_0040);
        issue(2'b00, 12'h000, 64'd0, 64'h8000_0050, 3'b010, "ebreak", 64'd0, 1'b1, 64'h8000_0100, 1'b1);
        rd(12'h342, "ebreak_cause", 64'd3);
        issue(2'b01, 12'h301, 64'd0, PC0, 3'b000, "misa_wr", 64'h8000_0000_0000_0100, 1'b1, 64'h8000_0100, 1'b1);
        rd(12'h342, "misa_cause", 64'd2);
        quiet();

        issue8(2'b01, 12'hB00, 64'hFD, "c8_wr", {56'd0, mdl_cyc[7:0]});
        issue8(2'b10, 12'hB00, 64'd0, "c8_fd", 64'hFD);
        issue8(2'b10, 12'hB00, 64'd0, "c8_fe", 64'hFE);
        issue8(2'b10, 12'hB00, 64'd0, "c8_ff", 64'hFF);
        issue8(2'b10, 12'hB00, 64'd0, "c8_wrap", 64'h00);
        issue8(2'b01, 12'hB02, 64'h42, "ir8_wr", 64'd5);
        issue8(2'b10, 12'hB02, 64'd0, "ir8_held", 64'h42);
        issue8(2'b10, 12'hB02, 64'd0, "ir8_inc", 64'h43);
        quiet();
        @(posedge clk); #1;

        check_val("sb_drain", 64'(exp_q.size() + exp8_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
